// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V control path:
// FSM states, opcode constants, ALU control encodings and per-state control words.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECUTEI = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // fetch marks the state whose IRWrite/PCUpdate follow mem_ready.
    typedef struct packed {
        logic       fetch;
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.fetch      = 1'b1;
                c.alu_src_b  = 2'b10;
                c.result_src = 2'b10;
            end
            S_DECODE: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_MEMREAD: c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: c.reg_write = 1'b1;
            S_JAL: begin
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b10;
                c.pc_update = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a = 2'b10;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction function fields onto the 3-bit ALU control.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type can subtract; addi with imm[10]=1 must stay add.
                    3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects, with optional wait-on-memory handshaking.
module multicycle_controller
    import riscv_pkg::*;
#(
    parameter bit USE_MEM_READY = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       IllegalOp
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   mem_rdy;
    logic   op_illegal;
    logic   pc_update;

    always_comb mem_rdy = USE_MEM_READY ? mem_ready : 1'b1;

    always_comb begin
        state_d    = state_q;
        op_illegal = 1'b0;
        case (state_q)
            S_FETCH: if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default: begin
                        state_d    = S_FETCH;
                        op_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
        // Control word is registered from the next state so outputs are Moore-clean.
        ctrl_d = state_ctrl(state_d);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            ctrl_q  <= state_ctrl(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    always_comb pc_update = ctrl_q.pc_update | (ctrl_q.fetch & mem_rdy);

    // Write strobes are gated by reset so nothing commits while it is held.
    always_comb begin
        PCWrite   = ~reset & (pc_update | (ctrl_q.branch & Zero));
        IRWrite   = ~reset & ctrl_q.fetch & mem_rdy;
        RegWrite  = ~reset & ctrl_q.reg_write;
        MemWrite  = ~reset & ctrl_q.mem_write;
        IllegalOp = ~reset & op_illegal;
        AdrSrc    = ctrl_q.adr_src;
        ResultSrc = ctrl_q.result_src;
        ALUSrcA   = ctrl_q.alu_src_a;
        ALUSrcB   = ctrl_q.alu_src_b;
    end

    always_comb begin
        case (op)
            OP_LW, OP_ITYPE: ImmSrc = 2'b00;
            OP_SW:           ImmSrc = 2'b01;
            OP_BEQ:          ImmSrc = 2'b10;
            OP_JAL:          ImmSrc = 2'b11;
            default:         ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (ctrl_q.alu_op),
        .op5        (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .ALUControl (ALUControl)
    );

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter USE_MEM_READY, default 1; when 1, memory states wait on mem_ready, when 0, mem_ready is treated as constant 1.
REQ-002 SHALL have port clk, input, 1 bit: the only clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port op, input, 7 bits: instruction opcode field from the instruction register.
REQ-005 SHALL have ports funct3 (input, 3 bits) and funct7b5 (input, 1 bit): instruction function fields.
REQ-006 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-007 SHALL have port mem_ready, input, 1 bit: memory access completes in the current cycle.
REQ-008 SHALL have outputs PCWrite, AdrSrc, MemWrite, IRWrite and RegWrite, each 1 bit.
REQ-009 SHALL have outputs ResultSrc, ALUSrcA, ALUSrcB and ImmSrc, each 2 bits.
REQ-010 SHALL have output ALUControl, 3 bits, with encoding add=000, sub=001, and=010, or=011, slt=101.
REQ-011 SHALL have output IllegalOp, 1 bit: one-cycle pulse when an unsupported opcode is decoded.

Function
REQ-012 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, ALUWB, EXECUTEI, JAL, BEQ.
REQ-013 SHALL make these transitions:
- FETCH->DECODE when mem_ready=1, else stay in FETCH.
- DECODE->MEMADR for lw (0000011) or sw (0100011).
- DECODE->EXECUTER for R-type (0110011).
- DECODE->EXECUTEI for I-type ALU (0010011).
- DECODE->JAL for jal (1101111).
- DECODE->BEQ for beq (1100011).
- DECODE->FETCH for any other opcode.
REQ-014 SHALL leave MEMADR for MEMREAD when op=lw and for MEMWRITE otherwise.
REQ-015 SHALL hold MEMREAD and MEMWRITE until mem_ready=1, then go MEMREAD->MEMWB and MEMWRITE->FETCH.
REQ-016 SHALL go EXECUTER->ALUWB and EXECUTEI->ALUWB; SHALL go MEMWB, ALUWB, JAL and BEQ ->FETCH unconditionally.
REQ-017 SHALL drive per-state outputs as listed below; every signal not listed is 0.
- FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=mem_ready.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
- MEMADR and EXECUTEI: ALUSrcA=10, ALUSrcB=01; ALUOp=00 in MEMADR, 10 in EXECUTEI.
- MEMREAD: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01, RegWrite=1.
- MEMWRITE: AdrSrc=1, MemWrite=1 (held until mem_ready).
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
- ALUWB: ResultSrc=00, RegWrite=1.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-018 SHALL compute PCWrite = PCUpdate OR (Branch AND Zero), combinationally.
REQ-019 SHALL decode ImmSrc combinationally from op: lw/I-type=00, sw=01, beq=10, jal=11, others=00.
REQ-020 SHALL decode ALUControl from ALUOp as follows:
- ALUOp 00 -> add; ALUOp 01 -> sub; ALUOp 11 -> add.
- ALUOp 10, funct3=000 -> sub if op[5] AND funct7b5, else add.
- ALUOp 10, funct3=010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-021 SHALL assert IllegalOp only in the DECODE cycle that takes the DECODE->FETCH illegal path.
REQ-022 SHALL make every instruction take these cycle counts with mem_ready held at 1: lw 5, sw 4, R/I 4, jal 3, beq 3, illegal 2.

Reset
REQ-023 SHALL force state to FETCH immediately on reset=1, independent of clk, including mid-instruction.
REQ-024 SHALL drive FETCH outputs during reset, with IRWrite, PCWrite, RegWrite and MemWrite forced to 0 while reset=1.
REQ-025 SHALL start the first FETCH on the first rising clk edge after reset deasserts.

Structure
REQ-026 SHALL place the state enumeration, opcode constants and ALUControl encodings in shared package riscv_pkg.
REQ-027 SHALL instantiate one sub-module, alu_decoder, implementing REQ-020 with inputs ALUOp, op[5], funct3, funct7b5 and output ALUControl.
REQ-028 SHALL keep ALUOp internal, with no output port.

Verification
REQ-029 SHALL cover lw (op=0000011) with mem_ready=1: FETCH, DECODE, MEMADR, MEMREAD, MEMWB in 5 cycles, and RegWrite=1 with ResultSrc=01 in cycle 5 only.
REQ-030 SHALL cover sw with mem_ready=0 for 3 cycles in MEMWRITE: MemWrite=1 for 4 consecutive cycles, then FETCH.
REQ-031 SHALL cover beq with Zero=1, then Zero=0: PCWrite=1 in the BEQ cycle for Zero=1 only, with ALUControl=001.
REQ-032 SHALL cover sub (op=0110011, funct3=000, funct7b5=1): ALUControl=001 in EXECUTER; with op=0010011 and the same funct fields: ALUControl=000.
REQ-033 SHALL cover op=1111111: IllegalOp pulses for 1 cycle in DECODE, then FETCH, with no RegWrite or MemWrite.
REQ-034 SHALL cover reset asserted during MEMREAD, off-edge: state is FETCH before the next clk edge and MemWrite/RegWrite stay 0.
